uart_autobaud: RTL and testbench

- Measures the bit period of an incoming 0x55 calibration character (8N1) on the synchronized RX line.
- Produces the 15-bit divider consumed by the UART baud generator (16x oversampling).
- Sits upstream of the UART configuration path. While measuring, the system holds the UART receiver disabled. On completion, software or glue logic writes divider_o into the divider register.

---
 rtl/uart_autobaud.sv | 172 +++++++++++++++++
 tb/tb_uart_autobaud.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// Measures the bit period of an incoming 0x55 calibration character and derives the
// 16x-oversampling baud divider. Optional pulse-width plausibility check: UART_AUTOBAUD_CHECK_EN.
module uart_autobaud #(
   parameter int unsigned DEFAULT_DIVIDER = 53,
   parameter int unsigned TIMEOUT_CYCLES  = 4194303
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        rx_i,
   output logic [14:0] divider_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o
);

   typedef enum logic [2:0] {IDLE, ARMED, MEASURE, WAIT_STOP, CALC} state_t;

   localparam logic [22:0] CntMax     = '1;
   localparam logic [22:0] TimeoutCnt = 23'(TIMEOUT_CYCLES);
   localparam logic [14:0] DefaultDiv = 15'(DEFAULT_DIVIDER);

   state_t      state_q;
   logic        rxPrev_q;
   logic        seenHigh_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;
   logic [22:0] periodCnt_q;
   logic [22:0] gapCnt_q;
   logic [1:0]  fallCnt_q;
   logic [14:0] divider_q;

   logic        fall;
   logic        rise;
   logic        edgeSeen;
   logic        widthBad;
   logic        calcOk;
   logic [16:0] quot;

   assign fall     = rxPrev_q & ~rx_i;
   assign rise     = ~rxPrev_q & rx_i;
   assign edgeSeen = fall | rise;

   // Eight bit times span 128 baud ticks, so a rounded C/128 is the tick period.
   assign quot   = 17'(({1'b0, periodCnt_q} + 24'd64) >> 7);
   assign calcOk = (quot != 17'd0) && (quot <= 17'd32768);

`ifdef UART_AUTOBAUD_CHECK_EN
   logic [22:0] startWidth_q;
   logic        widthSeen_q;
   logic [22:0] pulseWidth;
   logic [22:0] widthDiff;

   assign pulseWidth = gapCnt_q + 23'd1;
   assign widthDiff  = (pulseWidth >= startWidth_q) ? (pulseWidth - startWidth_q)
                                                    : (startWidth_q - pulseWidth);
   assign widthBad   = widthSeen_q && (widthDiff > (startWidth_q >> 2));

   // The start bit is the reference; every later pulse must stay within a quarter of it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         startWidth_q <= '0;
         widthSeen_q  <= 1'b0;
      end else if (state_q == ARMED) begin
         widthSeen_q  <= 1'b0;
      end else if ((state_q == MEASURE) && rise && !widthSeen_q) begin
         startWidth_q <= pulseWidth;
         widthSeen_q  <= 1'b1;
      end
   end
`else
   assign widthBad = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         rxPrev_q    <= 1'b1;
         seenHigh_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         periodCnt_q <= '0;
         gapCnt_q    <= '0;
         fallCnt_q   <= '0;
         divider_q   <= DefaultDiv;
      end else begin
         rxPrev_q <= rx_i;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         if ((state_q != IDLE) && abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     state_q    <= ARMED;
                     busy_q     <= 1'b1;
                     gapCnt_q   <= '0;
                     seenHigh_q <= 1'b0;
                  end
               end
               ARMED: begin
                  gapCnt_q <= gapCnt_q + 23'd1;
                  if (gapCnt_q == TimeoutCnt) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                  end else if (seenHigh_q && fall) begin
                     state_q     <= MEASURE;
                     periodCnt_q <= '0;
                     gapCnt_q    <= '0;
                     fallCnt_q   <= '0;
                  end else if (rx_i) begin
                     seenHigh_q <= 1'b1;
                  end
               end
               MEASURE: begin
                  if ((gapCnt_q == TimeoutCnt) || (periodCnt_q == CntMax) ||
                      (edgeSeen && widthBad)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                  end else begin
                     periodCnt_q <= periodCnt_q + 23'd1;
                     gapCnt_q    <= edgeSeen ? '0 : (gapCnt_q + 23'd1);
                     if (fall) begin
                        fallCnt_q <= fallCnt_q + 2'd1;
                        if (fallCnt_q == 2'd3) begin
                           state_q <= WAIT_STOP;
                        end
                     end
                  end
               end
               WAIT_STOP: begin
                  gapCnt_q <= gapCnt_q + 23'd1;
                  if (gapCnt_q == TimeoutCnt) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                  end else if (rise) begin
                     state_q <= CALC;
                  end
               end
               CALC: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (calcOk) begin
                     divider_q <= 15'(quot - 17'd1);
                     done_q    <= 1'b1;
                  end else begin
                     error_q   <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign divider_o = divider_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign error_o   = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Randomized bench for uart_autobaud: drives 0x55 frames with chosen bit widths and compares
// the outcome against an arithmetic model of the calibration rules.
module tb_uart_autobaud;

   localparam int Tmo = 3000;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        start_i;
   logic        abort_i;
   logic        rx_i;
   logic [14:0] divider_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   int testsRun    = 0;
   int testsFailed = 0;
   int doneSeen    = 0;
   int errorSeen   = 0;
   int bothSeen    = 0;
   int cyc         = 0;
   int doneCyc     = 0;
   int riseCyc     = 0;
   int segLen[10];
   logic [7:0]  calib = 8'h55;
   logic [14:0] modelDivider = 15'd53;
   bit checkEn;

   uart_autobaud #(.DEFAULT_DIVIDER(53), .TIMEOUT_CYCLES(Tmo)) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .start_i  (start_i),
      .abort_i  (abort_i),
      .rx_i     (rx_i),
      .divider_o(divider_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .error_o  (error_o)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   // Pulse monitor sampled on the falling edge, away from the active edge.
   always @(negedge clk_i) begin
      if (done_o) begin
         doneSeen++;
         doneCyc = cyc;
      end
      if (error_o) errorSeen++;
      if (done_o && error_o) bothSeen++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Start pulse, idle-high lead-in, then the ten segments of a 0x55 frame.
   task automatic applyStimulus(input int idleLen, input bit doubleStart, input int abortAfterSeg);
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      rx_i = 1'b1;
      checkOutput("busy after start", busy_o, 1);
      tick(1);
      if (doubleStart) start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      tick(idleLen);
      for (int k = 0; k < 10; k++) begin
         if (k == 0) rx_i = 1'b0;
         else if (k == 9) rx_i = 1'b1;
         else rx_i = calib[k-1];
         if (k == 9) riseCyc = cyc;
         if (k == abortAfterSeg) begin
            abort_i = 1'b1;
            tick(1);
            abort_i = 1'b0;
            checkOutput("busy after abort", busy_o, 0);
            tick(segLen[k] - 1);
         end else begin
            tick(segLen[k]);
         end
      end
      rx_i = 1'b1;
      tick(3);
   endtask

   // Reference: C is the span of the start bit plus data bits 0..6; the rounded C/128 must be
   // in 1..32768, and with the width check every pulse up to the 4th fall must match the start bit.
   task automatic runFrame(input string tag, input int idleLen, input bit doubleStart);
      longint c;
      longint q;
      bit ok;
      int d0, e0;
      c = 0;
      for (int k = 0; k < 8; k++) c += segLen[k];
      q = (c + 64) / 128;
      ok = (q >= 1) && (q <= 32768);
      if (checkEn) begin
         for (int k = 1; k < 8; k++) begin
            int diff;
            diff = segLen[k] - segLen[0];
            if (diff < 0) diff = -diff;
            if (diff > segLen[0] / 4) ok = 1'b0;
         end
      end
      d0 = doneSeen;
      e0 = errorSeen;
      applyStimulus(idleLen, doubleStart, -1);
      if (ok) modelDivider = 15'(q - 1);
      checkOutput({tag, " done count"}, doneSeen - d0, ok ? 1 : 0);
      checkOutput({tag, " error count"}, errorSeen - e0, ok ? 0 : 1);
      checkOutput({tag, " divider"}, divider_o, modelDivider);
      checkOutput({tag, " busy idle"}, busy_o, 0);
      if (ok) checkOutput({tag, " done latency"}, doneCyc - riseCyc, 2);
   endtask

   task automatic setUniform(input int t);
      for (int k = 0; k < 10; k++) segLen[k] = t;
   endtask

   initial begin
      int t, d0, e0;
`ifdef UART_AUTOBAUD_CHECK_EN
      checkEn = 1'b1;
`else
      checkEn = 1'b0;
`endif
      rst_n_i = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
      rx_i    = 1'b1;
      tick(2);
      checkOutput("reset divider", divider_o, 53);
      checkOutput("reset busy", busy_o, 0);
      checkOutput("reset done", done_o, 0);
      checkOutput("reset error", error_o, 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      tick(2);

      setUniform(868);
      runFrame("baud115200", 5, 1'b0);
      checkOutput("baud115200 fixed divider", divider_o, 53);

      setUniform(300);
      runFrame("t300", 3, 1'b0);
      checkOutput("t300 fixed divider", divider_o, 18);

      for (int i = 0; i < 8; i++) begin
         t = $urandom_range(8, 500);
         for (int k = 0; k < 10; k++) begin
            segLen[k] = (t >= 16) ? (t + $urandom_range(0, 2) - 1) : t;
         end
         runFrame("random", $urandom_range(2, 20), 1'b0);
      end

      setUniform(4);
      runFrame("fast line", 4, 1'b1);
      tick(5);
      checkOutput("busy after ignored start", busy_o, 0);

      d0 = doneSeen;
      e0 = errorSeen;
      abort_i = 1'b1;
      tick(2);
      abort_i = 1'b0;
      checkOutput("abort in idle busy", busy_o, 0);

      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      rx_i = 1'b1;
      tick(Tmo - 10);
      checkOutput("timeout not early", errorSeen - e0, 0);
      tick(30);
      checkOutput("timeout error count", errorSeen - e0, 1);
      checkOutput("timeout divider", divider_o, modelDivider);
      checkOutput("timeout busy", busy_o, 0);

      setUniform(50);
      e0 = errorSeen;
      applyStimulus(4, 1'b0, 3);
      tick(Tmo + 20);
      checkOutput("abort no done", doneSeen - d0, 0);
      checkOutput("abort no error", errorSeen - e0, 0);
      checkOutput("abort divider", divider_o, modelDivider);

      setUniform(868);
      segLen[4] = 1302;
      runFrame("stretched bit3", 6, 1'b0);

      setUniform(200);
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      tick(4);
      rx_i = 1'b0;
      tick(100);
      @(posedge clk_i);
      #3;
      rst_n_i = 1'b0;
      #1;
      checkOutput("async reset divider", divider_o, 53);
      checkOutput("async reset busy", busy_o, 0);
      checkOutput("async reset done", done_o, 0);
      checkOutput("async reset error", error_o, 0);
      rx_i = 1'b1;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      tick(3);

      checkOutput("done and error together", bothSeen, 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
